// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative vectoring-mode CORDIC returning atan2(y, x) or |(x, y)| as float32
//
// Ports:
//   clk     system clock
//   rst     asynchronous active-low reset
//   clk_en  custom-instruction clock enable; 0 freezes every register
//   start   one-cycle request, samples dataa/datab/n while idle
//   dataa   x operand, float32
//   datab   y operand, float32
//   n       0 = angle in radians, 1 = magnitude
//   done    one-cycle pulse when result is valid
//   result  float32 result, held until the next operation completes
module cordic_vectoring #(
  parameter int M             = 15,
  parameter int W             = 32,
  parameter int FRACTION_BITS = 26,
  parameter int DW            = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         start,
  input  logic [W-1:0] dataa,
  input  logic [W-1:0] datab,
  input  logic         n,
  output logic         done,
  output logic [W-1:0] result
);

  // float mantissa with hidden one, aligned so an exponent of 127 lands on 1.0
  localparam int MB = FRACTION_BITS + 1;
  localparam logic [DW-1:0]        SAT      = {{(DW-MB){1'b0}}, {MB{1'b1}}};
  localparam logic signed [DW-1:0] PI       = DW'(210828714);
  localparam logic [27:0]          INV_K    = 28'h26DD3B4;
  localparam logic [7:0]           EXP_BIAS = 8'(127 - FRACTION_BITS);

  typedef enum logic [2:0] {IDLE, PRE, ITER, SCALE, PACK} state_t;

  state_t                 r_state, w_next;
  logic [W-1:0]           r_a, r_b, r_result;
  logic                   r_n, r_zero, r_done;
  logic [4:0]             r_i;
  logic signed [DW-1:0]   r_x, r_y, r_z, r_v;

  logic signed [DW-1:0]   w_x0, w_y0, w_xs, w_ys, w_at, w_mag;
  logic signed [DW+28:0]  w_prod;
  logic [DW-1:0]          w_abs, w_norm;
  logic [4:0]             w_p, w_sh;
  logic [7:0]             w_exp;
  logic [W-1:0]           w_float;

  function automatic logic signed [DW-1:0] f2fix(input logic [W-1:0] f);
    logic [7:0]    e;
    logic [7:0]    sh;
    logic [MB-1:0] m;
    logic [DW-1:0] mag;
    e   = f[30:23];
    sh  = 8'd127 - e;
    m   = {1'b1, f[22:0], 3'b000};
    mag = '0;
    if (e == 8'd0)        mag = '0;
    else if (e >= 8'd128) mag = SAT;
    else if (sh < 8'(MB)) mag = {{(DW-MB){1'b0}}, m >> sh};
    return f[W-1] ? -$signed(mag) : $signed(mag);
  endfunction

  // round(atan(2^-i) * 2^26); beyond i=11 the value is just 2^(26-i)
  function automatic logic signed [DW-1:0] atan_lut(input logic [4:0] i);
    int v;
    case (i)
      5'd0:  v = 52707179;
      5'd1:  v = 31114864;
      5'd2:  v = 16440240;
      5'd3:  v = 8345322;
      5'd4:  v = 4188855;
      5'd5:  v = 2096470;
      5'd6:  v = 1048491;
      5'd7:  v = 524277;
      5'd8:  v = 262143;
      5'd9:  v = 131072;
      5'd10: v = 65536;
      5'd11: v = 32768;
      5'd12: v = 16384;
      5'd13: v = 8192;
      5'd14: v = 4096;
      5'd15: v = 2048;
      5'd16: v = 1024;
      5'd17: v = 512;
      5'd18: v = 256;
      5'd19: v = 128;
      5'd20: v = 64;
      5'd21: v = 32;
      5'd22: v = 16;
      5'd23: v = 8;
      default: v = 0;
    endcase
    return DW'(v);
  endfunction

  always_comb begin
    w_x0   = f2fix(r_a);
    w_y0   = f2fix(r_b);
    w_xs   = r_x >>> r_i;
    w_ys   = r_y >>> r_i;
    w_at   = atan_lut(r_i);
    w_prod = r_x * $signed({1'b0, INV_K});
    w_mag  = DW'(w_prod >>> FRACTION_BITS);
  end

  // fixed -> float: normalise so the leading one sits at the top bit, then truncate
  always_comb begin
    w_abs = r_v[DW-1] ? -r_v : r_v;
    w_p   = '0;
    for (int k = 0; k < DW; k++) begin
      if (w_abs[k]) w_p = 5'(k);
    end
    w_sh   = 5'(DW-1) - w_p;
    w_norm = w_abs << w_sh;
    w_exp  = EXP_BIAS + {3'b000, w_p};
    if (r_v == '0) w_float = '0;
    else           w_float = {r_v[DW-1], w_exp, 23'(w_norm >> (DW-24))};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_state <= IDLE;
    else if (clk_en) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = PRE;
      PRE:     w_next = ITER;
      ITER:    if (r_i == 5'(M-1)) w_next = SCALE;
      SCALE:   w_next = PACK;
      PACK:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_n      <= 1'b0;
      r_zero   <= 1'b0;
      r_i      <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_v      <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (clk_en) begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a <= dataa;
            r_b <= datab;
            r_n <= n;
          end
        end
        PRE: begin
          // left half-plane is folded onto the right; z starts at +/-pi to compensate
          if (w_x0[DW-1]) begin
            r_x <= -w_x0;
            r_y <= -w_y0;
            r_z <= w_y0[DW-1] ? -PI : PI;
          end else begin
            r_x <= w_x0;
            r_y <= w_y0;
            r_z <= '0;
          end
          // a zero vector would still accumulate angle because y==0 counts as y>=0
          r_zero <= (w_x0 == '0) && (w_y0 == '0);
          r_i    <= '0;
        end
        ITER: begin
          if (!r_y[DW-1]) begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_at;
          end else begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_at;
          end
          r_i <= r_i + 5'd1;
        end
        SCALE: r_v <= r_zero ? '0 : (r_n ? w_mag : r_z);
        PACK: begin
          r_result <= w_float;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_cordic_vectoring.sv
// tb/tb_cordic_vectoring.sv - directed vector bench for cordic_vectoring
module tb_cordic_vectoring;
  localparam int  M   = 15;
  localparam int  LAT = M + 4;
  localparam real TOL = 1.3e-4;

  logic        clk = 1'b0;
  logic        rst, clk_en, start, n, done;
  logic [31:0] dataa, datab, result;
  int          total = 0;
  int          bad   = 0;

  cordic_vectoring #(.M(M)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .n(n), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        n;
    real         exp;
    logic        exact;
  } vec_t;

  vec_t tv[12];

  function automatic real f2r(input logic [31:0] f);
    real r;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    r = $itor({8'd0, 1'b1, f[22:0]});
    e = int'(f[30:23]) - 150;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return f[31] ? -r : r;
  endfunction

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_val(input string nm, input logic [31:0] bits, input real exp, input logic exact);
    real d;
    total++;
    d = f2r(bits) - exp;
    if (d < 0.0) d = -d;
    if ((exact && bits != 32'h0) || (!exact && d > TOL)) begin
      bad++;
      $display("FAIL %s: got %h (%f) want %f", nm, bits, f2r(bits), exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic nn,
                        output int lat, output logic [31:0] res);
    dataa = a; datab = b; n = nn; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = result;
  endtask

  // kind: 1 = extra start at ev, 2 = clk_en low for 5 cycles from ev, 3 = reset pulse at ev
  task automatic run_custom(input logic [31:0] a, input logic [31:0] b, input logic nn,
                            input int kind, input int ev,
                            output int first, output int pulses, output logic [31:0] res);
    first = 0; pulses = 0; res = 32'h0;
    dataa = a; datab = b; n = nn; start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        pulses++;
        if (first == 0) begin first = c; res = result; end
      end
      if (kind == 1 && c == ev) begin
        dataa = 32'h0; datab = 32'h0; n = 1'b1; start = 1'b1;
      end
      if (kind == 2 && c == ev)     clk_en = 1'b0;
      if (kind == 2 && c == ev + 5) clk_en = 1'b1;
      if (kind == 3 && c == ev) begin
        rst = 1'b0;
        #1;
        chk_int("rst_mid_done", int'(done), 0);
        chk_int("rst_mid_result", int'(result), 0);
      end
      if (kind == 3 && c == ev + 1) rst = 1'b1;
    end
  endtask

  initial begin
    int          lat, first, pulses;
    logic [31:0] res;

    tv[0]  = '{32'h3F800000, 32'h3F800000, 1'b0,  0.7853982, 1'b0};
    tv[1]  = '{32'h3F800000, 32'h3F800000, 1'b1,  1.4142136, 1'b0};
    tv[2]  = '{32'hBF800000, 32'h00000000, 1'b0,  3.1415927, 1'b0};
    tv[3]  = '{32'hBF800000, 32'h80000000, 1'b0,  3.1415927, 1'b0};
    tv[4]  = '{32'hBF800000, 32'hBDCCCCCD, 1'b0, -3.0419240, 1'b0};
    tv[5]  = '{32'h00000000, 32'hBF000000, 1'b0, -1.5707963, 1'b0};
    tv[6]  = '{32'h00000000, 32'hBF000000, 1'b1,  0.5000000, 1'b0};
    tv[7]  = '{32'h00000000, 32'h00000000, 1'b0,  0.0,       1'b1};
    tv[8]  = '{32'h00000000, 32'h00000000, 1'b1,  0.0,       1'b1};
    tv[9]  = '{32'h40800000, 32'h3F800000, 1'b0,  0.4636476, 1'b0};
    tv[10] = '{32'h00000000, 32'h3F000000, 1'b0,  1.5707963, 1'b0};
    tv[11] = '{32'hBF800000, 32'h00000000, 1'b1,  1.0000000, 1'b0};

    rst = 1'b0; clk_en = 1'b1; start = 1'b0; n = 1'b0; dataa = '0; datab = '0;
    repeat (3) @(negedge clk);
    chk_int("reset_done", int'(done), 0);
    chk_int("reset_result", int'(result), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_int("idle_done", int'(done), 0);
    chk_int("idle_result", int'(result), 0);

    for (int i = 0; i < 12; i++) begin
      run_op(tv[i].a, tv[i].b, tv[i].n, lat, res);
      chk_int($sformatf("vec%0d_latency", i), lat, LAT);
      chk_val($sformatf("vec%0d_value", i), res, tv[i].exp, tv[i].exact);
    end
    repeat (3) @(negedge clk);

    // start while busy is ignored; done pulses once
    run_custom(32'h3F800000, 32'h3F800000, 1'b0, 1, 3, first, pulses, res);
    chk_int("busy_start_latency", first, LAT);
    chk_int("busy_start_pulses", pulses, 1);
    chk_val("busy_start_value", res, 0.7853982, 1'b0);
    chk_int("done_cleared", int'(done), 0);
    chk_val("result_held", result, 0.7853982, 1'b0);

    // start coincident with done
    run_op(32'h3F800000, 32'h3F800000, 1'b1, lat, res);
    chk_int("b2b_first_latency", lat, LAT);
    run_op(32'hBF800000, 32'h00000000, 1'b0, lat, res);
    chk_int("b2b_second_latency", lat, LAT);
    chk_val("b2b_second_value", res, 3.1415927, 1'b0);
    repeat (3) @(negedge clk);

    // clk_en freeze mid-ITER
    run_custom(32'h3F800000, 32'h3F800000, 1'b0, 2, 5, first, pulses, res);
    chk_int("stall_latency", first, LAT + 5);
    chk_int("stall_pulses", pulses, 1);
    chk_val("stall_value", res, 0.7853982, 1'b0);

    // reset mid-ITER abandons the operation
    run_custom(32'h00000000, 32'hBF000000, 1'b1, 3, 8, first, pulses, res);
    chk_int("rst_abandon_pulses", pulses, 0);
    run_op(32'h3F800000, 32'h3F800000, 1'b1, lat, res);
    chk_int("after_rst_latency", lat, LAT);
    chk_val("after_rst_value", res, 1.4142136, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cordic_vectoring.md
Name: cordic_vectoring

Overview:
- Iterative CORDIC in vectoring mode: takes a float32 vector (x, y) and returns atan2(y, x) or the magnitude sqrt(x²+y²) as float32.
- Inverse-direction companion to the existing rotation-mode cosine core.
- Attaches to the Nios II as a multi-cycle custom instruction (clk_en/start/done).
- Shares the angle-table format (26 fraction bits) and the 1/K gain constant with the rotation core.

Parameters:
- M, 15, number of CORDIC iterations (1..24)
- W, 32, float word width (IEEE-754 single)
- FRACTION_BITS, 26, fraction bits of internal fixed point
- DW, 30, signed internal width of x, y, z (1 sign, 3 integer, 26 fraction)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- clk_en  in  1  custom-instruction clock enable; 0 freezes all state
- start  in  1  single-cycle request; samples dataa/datab/n
- dataa  in  32  x operand, float32
- datab  in  32  y operand, float32
- n  in  1  0 = return angle (radians), 1 = return magnitude
- done  out  1  one-cycle pulse, result valid
- result  out  32  float32 result, held until next start

Behaviour:
- Reset (rst=0, any time, asynchronous): state=IDLE, done=0, result=32'h0, all x/y/z registers 0. Any operation in flight is abandoned.
- All sequential updates require clk_en=1. With clk_en=0, state, counters and done hold their values.
- FSM states: IDLE, PRE, ITER, SCALE, PACK.
- IDLE: on start=1, capture dataa, datab and n → PRE. start in any other state is ignored.
- PRE (1 cycle), float→fixed for each operand:
  - e==0 → 0.
  - e>=128 → saturate to ±(2 − 2^-26).
  - Otherwise value = ±({1,mant} << 3) >> (127 − e), which truncates; a shift of 27 or more gives 0.
- PRE, quadrant pre-rotation:
  - If x<0: x=−x, y=−y, z0=+PI when original y>=0, else −PI.
  - Otherwise z0=0.
  - Clear iteration counter i.
  - → ITER.
- ITER (exactly M cycles, i=0..M−1):
  - If y>=0: x+=y>>>i, y−=x>>>i, z+=ATAN[i].
  - Else: x−=y>>>i, y+=x>>>i, z−=ATAN[i].
  - Updates use old values (simultaneous assignment).
  - After i==M−1 → SCALE.
- ATAN[i] = round(atan(2^-i)·2^26). ATAN[0]=52707179. PI=210828714.
- SCALE (1 cycle): mag = (x · INV_K) >>> 26, with INV_K = 28'h26DD3B4 (≈0.6072529). Selected value v = n ? mag : z. → PACK.
- PACK (1 cycle), fixed→float of v:
  - v==0 → 32'h00000000.
  - Otherwise sign = v[DW−1]; magnitude |v|; p = leading-one position; exponent = 127 + p − 26; mantissa = 23 bits below the leading one, left-aligned and truncated (no rounding).
  - Register result, assert done=1 for exactly one cycle → IDLE.
- Latency: start sampled at edge k; done high in the cycle following edge k+M+3. Back-to-back: a new start is accepted in the cycle done is high, because the FSM is already in IDLE.
- Boundary cases:
  - x=y=0: angle 0, magnitude 0.
  - x<0, y=0: +π.
  - x=0 (positive zero), y≠0: ±π/2.
  - Negative-zero inputs are treated as 0.
  - Worst-case intermediate: |x|,|y| < 2 gives x·K < 4.66, inside DW range, so no overflow.
- Accuracy: absolute error ≤ 2^-13 for both outputs over the input domain |x|,|y| < 2.

Test Plan:
- x=0x3F800000 (1.0), y=0x3F800000 (1.0), n=0 → done at start+M+4 cycles, result ≈0.785398 (0x3F490FDB), |err| < 1.3e-4. Repeat with n=1 → ≈1.414214 (0x3FB504F3), same tolerance.
- x=0xBF800000 (−1.0), y=0 → ≈+3.141593 (0x40490FDB). Then y=0x80000000 → still +π. Then y=0xBDCCCCCD (−0.1) → ≈−3.041924.
- x=0, y=0xBF000000 (−0.5) → angle ≈−1.570796, magnitude ≈0.5. Then x=y=0 → both results exactly 0x00000000.
- Pulse start again 3 cycles after the first start → ignored: exactly one done pulse at the original latency. Then start coincident with done → second done M+4 cycles later.
- Hold clk_en=0 for 5 cycles mid-ITER → done delayed by exactly 5 cycles, result unchanged. Then assert rst=0 mid-ITER → done=0 and result=0 immediately, FSM returns to IDLE, next start completes normally.
- x=0x40800000 (4.0, saturates), y=0x3F800000 → angle ≈0.463648 (atan(0.5)), with |err| < 1.3e-4.
